// File: rtl/ntsc_sync_decoder_pkg.sv
// Shared definitions for the NTSC sync decoder: FSM encoding, counter widths
// and default line/frame timing at a 50 MHz system clock.
package ntsc_sync_decoder_pkg;

  localparam int HCNT_W = 12;
  localparam int VCNT_W = 9;
  localparam int X_W    = 10;
  localparam int Y_W    = 9;
  localparam int CNT_W  = 8;

  localparam int DEF_H_TOTAL        = 3178;
  localparam int DEF_H_TOL          = 16;
  localparam int DEF_H_ACTIVE_START = 470;
  localparam int DEF_H_ACTIVE_LEN   = 640;
  localparam int DEF_PIX_DIV        = 4;
  localparam int DEF_V_ACTIVE_START = 20;
  localparam int DEF_V_ACTIVE_LINES = 240;
  localparam int DEF_LOCK_LINES     = 8;
  localparam int DEF_MISS_MAX       = 4;

  // Sync pins idle high; synchronizer flops reset to this level so that
  // leaving reset never fakes a falling edge.
  localparam logic SYNC_IDLE = 1'b1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } sync_state_t;

endpackage

// File: rtl/ntsc_sync_in.sv
// Two-flop synchronizer plus falling-edge detect for an active-low sync pin.
// The pulse is valid in the cycle after the second flop; state using it updates 3 clk after the pin edge.
module ntsc_sync_in
  import ntsc_sync_decoder_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sync_n,
  output logic fall
);

  logic meta;
  logic stable;
  logic stable_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta     <= SYNC_IDLE;
      stable   <= SYNC_IDLE;
      stable_d <= SYNC_IDLE;
    end else begin
      meta     <= sync_n;
      stable   <= meta;
      stable_d <= stable;
    end
  end

  assign fall = stable_d & ~stable;

endmodule

// File: rtl/ntsc_sync_decoder.sv
// NTSC sync receiver: measures line period, locks with a flywheel and regenerates x/y/active_video.
// Define NTSC_SYNC_STATS_EN to add the line_period and err_cnt status ports.
module ntsc_sync_decoder
  import ntsc_sync_decoder_pkg::*;
#(
  parameter int H_TOTAL        = DEF_H_TOTAL,
  parameter int H_TOL          = DEF_H_TOL,
  parameter int H_ACTIVE_START = DEF_H_ACTIVE_START,
  parameter int H_ACTIVE_LEN   = DEF_H_ACTIVE_LEN,
  parameter int PIX_DIV        = DEF_PIX_DIV,
  parameter int V_ACTIVE_START = DEF_V_ACTIVE_START,
  parameter int V_ACTIVE_LINES = DEF_V_ACTIVE_LINES,
  parameter int LOCK_LINES     = DEF_LOCK_LINES,
  parameter int MISS_MAX       = DEF_MISS_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync_in,
  input  logic             vsync_in,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic             active_video,
  output logic             locked
`ifdef NTSC_SYNC_STATS_EN
  ,
  output logic [HCNT_W-1:0] line_period,
  output logic [CNT_W-1:0]  err_cnt
`endif
);

  localparam logic [HCNT_W-1:0] LEN_MIN   = HCNT_W'(H_TOTAL - H_TOL);
  localparam logic [HCNT_W-1:0] LEN_MAX   = HCNT_W'(H_TOTAL + H_TOL);
  localparam logic [HCNT_W-1:0] H_START   = HCNT_W'(H_ACTIVE_START);
  localparam logic [HCNT_W-1:0] H_PRE     = HCNT_W'(H_ACTIVE_START - 1);
  localparam logic [HCNT_W-1:0] H_END     = HCNT_W'(H_ACTIVE_START + H_ACTIVE_LEN * PIX_DIV);
  localparam logic [VCNT_W-1:0] V_START   = VCNT_W'(V_ACTIVE_START);
  localparam logic [VCNT_W-1:0] V_END     = VCNT_W'(V_ACTIVE_START + V_ACTIVE_LINES);
  localparam logic [CNT_W-1:0]  PDIV_LAST = CNT_W'(PIX_DIV - 1);
  localparam logic [CNT_W-1:0]  GOOD_LAST = CNT_W'(LOCK_LINES - 1);
  localparam logic [CNT_W-1:0]  MISS_LAST = CNT_W'(MISS_MAX - 1);

  logic h_fall;
  logic v_fall;

  ntsc_sync_in u_hsync (.clk(clk), .rst(rst), .sync_n(hsync_in), .fall(h_fall));
  ntsc_sync_in u_vsync (.clk(clk), .rst(rst), .sync_n(vsync_in), .fall(v_fall));

  sync_state_t       state, state_next;
  logic [CNT_W-1:0]  good_cnt, good_cnt_next;
  logic [CNT_W-1:0]  miss_cnt, miss_cnt_next;
  logic [HCNT_W-1:0] hcnt;
  logic [HCNT_W-1:0] line_len;
  logic [VCNT_W-1:0] vcnt;
  logic [CNT_W-1:0]  pdiv;
  logic [X_W-1:0]    xcnt;
  logic              fly, line_start, good, bad;
  logic              h_win, v_win, show;

  // hcnt is 0 in the cycle after a line start, so the line that is ending
  // has lasted hcnt+1 clocks when the next start is seen.
  assign line_len   = (hcnt == '1) ? hcnt : hcnt + 1'b1;
  assign fly        = (state == LOCKED) && !h_fall && (line_len == LEN_MAX);
  assign line_start = h_fall | fly;
  assign good       = h_fall && (line_len >= LEN_MIN) && (line_len <= LEN_MAX);
  assign bad        = line_start && !good;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SEARCH;
      good_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      state    <= state_next;
      good_cnt <= good_cnt_next;
      miss_cnt <= miss_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    good_cnt_next = good_cnt;
    miss_cnt_next = miss_cnt;
    case (state)
      SEARCH: begin
        if (h_fall) begin
          state_next    = TRACK;
          good_cnt_next = '0;
        end
      end
      TRACK: begin
        if (good) begin
          if (good_cnt == GOOD_LAST) begin
            state_next    = LOCKED;
            miss_cnt_next = '0;
          end else begin
            good_cnt_next = good_cnt + 1'b1;
          end
        end else if (bad) begin
          state_next = SEARCH;
        end
      end
      LOCKED: begin
        if (good) begin
          miss_cnt_next = '0;
        end else if (bad) begin
          if (miss_cnt == MISS_LAST) state_next = SEARCH;
          else miss_cnt_next = miss_cnt + 1'b1;
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  // Pixel divider is re-phased one clock early so pdiv=0, x=0 coincide with hcnt==H_ACTIVE_START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
      pdiv <= '0;
      xcnt <= '0;
    end else begin
      if (line_start) hcnt <= '0;
      else if (hcnt != '1) hcnt <= hcnt + 1'b1;

      if (v_fall) vcnt <= '0;
      else if (line_start && vcnt != '1) vcnt <= vcnt + 1'b1;

      if (line_start || hcnt == H_PRE) begin
        pdiv <= '0;
        xcnt <= '0;
      end else if (pdiv == PDIV_LAST) begin
        pdiv <= '0;
        xcnt <= xcnt + 1'b1;
      end else begin
        pdiv <= pdiv + 1'b1;
      end
    end
  end

  assign h_win = (hcnt >= H_START) && (hcnt < H_END);
  assign v_win = (vcnt >= V_START) && (vcnt < V_END);
  assign show  = (state_next == LOCKED) && h_win && v_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked       <= 1'b0;
      active_video <= 1'b0;
      x            <= '0;
      y            <= '0;
    end else begin
      locked       <= (state_next == LOCKED);
      active_video <= show;
      x            <= show ? xcnt : '0;
      y            <= show ? Y_W'(vcnt - V_START) : '0;
    end
  end

`ifdef NTSC_SYNC_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_period <= '0;
      err_cnt     <= '0;
    end else begin
      if (h_fall) line_period <= line_len;
      if (bad && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ntsc_sync_decoder.sv
// Self-checking bench for ntsc_sync_decoder with a shortened line timing.
// Expected output values are queued with a target cycle and checked on the falling clock edge.
module tb_ntsc_sync_decoder;

  localparam int HT   = 400;
  localparam int HTOL = 16;
  localparam int HAS  = 60;
  localparam int HAL  = 64;
  localparam int PD   = 4;
  localparam int VAS  = 4;
  localparam int VAL  = 3;
  localparam int LL   = 8;
  localparam int MM   = 4;
  localparam int LOW  = 20;
  localparam int FLY  = HT + HTOL;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic [9:0] x;
  logic [8:0] y;
  logic       active_video;
  logic       locked;
`ifdef NTSC_SYNC_STATS_EN
  logic [11:0] line_period;
  logic [7:0]  err_cnt;
`endif

  ntsc_sync_decoder #(
    .H_TOTAL(HT), .H_TOL(HTOL), .H_ACTIVE_START(HAS), .H_ACTIVE_LEN(HAL),
    .PIX_DIV(PD), .V_ACTIVE_START(VAS), .V_ACTIVE_LINES(VAL),
    .LOCK_LINES(LL), .MISS_MAX(MM)
  ) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .x(x), .y(y), .active_video(active_video), .locked(locked)
`ifdef NTSC_SYNC_STATS_EN
    , .line_period(line_period), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    at;
    string name;
    logic  lk;
    logic  av;
    int    ex;
    int    ey;
  } exp_t;

  typedef struct {
    int   gap;
    logic lk;
  } line_t;

  exp_t  sb[$];
  int    total = 0;
  int    bad = 0;
  int    fall_cyc = 0;
  line_t tab [26];

  task automatic compare(input string name, input logic lk, input logic av, input int ex, input int ey);
    total++;
    if (locked !== lk || active_video !== av || x !== 10'(ex) || y !== 9'(ey)) begin
      bad++;
      $display("FAIL %s cyc=%0d got lk=%b av=%b x=%0d y=%0d want lk=%b av=%b x=%0d y=%0d",
               name, cyc, locked, active_video, x, y, lk, av, ex, ey);
    end else begin
      $display("ok   %s cyc=%0d lk=%b av=%b x=%0d y=%0d", name, cyc, locked, active_video, x, y);
    end
  endtask

  task automatic push(input int at, input string name, input logic lk, input logic av,
                      input int ex, input int ey);
    exp_t e;
    e.at = at; e.name = name; e.lk = lk; e.av = av; e.ex = ex; e.ey = ey;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        compare(sb[i].name, sb[i].lk, sb[i].av, sb[i].ex, sb[i].ey);
        sb.delete(i);
      end
    end
  end

  // Release the previous sync pulse, then drop hsync (and optionally vsync) gap clocks after the last fall.
  task automatic drive_fall(input int gap, input bit vs);
    while (cyc < fall_cyc + LOW) @(negedge clk);
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    while (cyc < fall_cyc + gap) @(negedge clk);
    hsync_in = 1'b0;
    if (vs) vsync_in = 1'b0;
    fall_cyc = cyc;
  endtask

  task automatic lock_line(input int gap, input logic lk_prev, input logic lk, input string tag);
    drive_fall(gap, 1'b0);
    push(fall_cyc + 2, {tag, "_pre"}, lk_prev, 1'b0, 0, 0);
    push(fall_cyc + 3, {tag, "_post"}, lk, 1'b0, 0, 0);
  endtask

  // Line k of a frame (k=0 is the line opened by the coincident vsync fall).
  task automatic frame_line(input int k, input bit vs, input bit detail);
    int base;
    bit win;
    int yk;
    drive_fall(HT, vs);
    base = fall_cyc + 3;
    win  = (k >= VAS) && (k < VAS + VAL);
    yk   = win ? k - VAS : 0;
    push(base + HAS, $sformatf("v%0d_before", k), 1'b1, 1'b0, 0, 0);
    push(base + HAS + 1, $sformatf("v%0d_first", k), 1'b1, win, 0, yk);
    if (detail && win) begin
      push(base + HAS + PD, $sformatf("v%0d_x0_hold", k), 1'b1, 1'b1, 0, yk);
      push(base + HAS + PD + 1, $sformatf("v%0d_x1", k), 1'b1, 1'b1, 1, yk);
      push(base + HAS + HAL * PD, $sformatf("v%0d_last", k), 1'b1, 1'b1, HAL - 1, yk);
      push(base + HAS + HAL * PD + 1, $sformatf("v%0d_end", k), 1'b1, 1'b0, 0, 0);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic prev;
    int   f;

    tab = '{'{100, 1'b0},
            '{HT, 1'b0}, '{HT, 1'b0}, '{HT, 1'b0}, '{HT, 1'b0},
            '{HT, 1'b0}, '{HT, 1'b0}, '{HT, 1'b0},
            '{HT, 1'b1}, '{HT, 1'b1},
            '{340, 1'b1}, '{HT - HTOL, 1'b1}, '{HT + HTOL, 1'b1},
            '{HT - HTOL - 1, 1'b1}, '{340, 1'b1}, '{340, 1'b1}, '{340, 1'b0},
            '{HT, 1'b0}, '{HT, 1'b0}, '{HT, 1'b0}, '{HT, 1'b0},
            '{HT, 1'b0}, '{HT, 1'b0}, '{HT, 1'b0}, '{HT, 1'b0},
            '{HT, 1'b1}};

    repeat (3) @(negedge clk);
    compare("reset_state", 1'b0, 1'b0, 0, 0);
    rst = 1'b0;

    // Lock, tolerance edges, miss counting and relock.
    prev = 1'b0;
    for (int i = 0; i < 26; i++) begin
      lock_line(tab[i].gap, prev, tab[i].lk, $sformatf("t%0d", i));
      prev = tab[i].lk;
    end
`ifdef NTSC_SYNC_STATS_EN
    repeat (5) @(negedge clk);
    total++;
    if (line_period !== 12'(HT)) begin
      bad++;
      $display("FAIL line_period got %0d want %0d", line_period, HT);
    end
    total++;
    if (err_cnt !== 8'd6) begin
      bad++;
      $display("FAIL err_cnt got %0d want 6", err_cnt);
    end
`endif

    // Flywheel: hsync stops, lock is lost on the 4th synthetic line start.
    f = fall_cyc + 3;
    for (int k = 1; k <= MM; k++) begin
      push(f + k * FLY - 1, $sformatf("fly%0d_pre", k), 1'b1, 1'b0, 0, 0);
      push(f + k * FLY, $sformatf("fly%0d_post", k), (k < MM), 1'b0, 0, 0);
    end
    while (cyc < fall_cyc + LOW) @(negedge clk);
    hsync_in = 1'b1;
    while (cyc < f + MM * FLY + 10) @(negedge clk);

    // Relock, then a frame whose first line has hsync and vsync falling together.
    for (int i = 0; i <= LL; i++) lock_line(HT, 1'b0, (i == LL), $sformatf("r%0d", i));
    frame_line(0, 1'b1, 1'b1);
    for (int k = 1; k <= VAS + VAL; k++) frame_line(k, 1'b0, 1'b1);

    // Reset in the middle of an active line, then a full relock.
    frame_line(0, 1'b1, 1'b0);
    for (int k = 1; k <= VAS; k++) frame_line(k, 1'b0, 1'b0);
    while (cyc < fall_cyc + 3 + HAS + 20) @(negedge clk);
    rst = 1'b1;
    #1;
    compare("rst_mid_line", 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i <= LL; i++) lock_line(HT, 1'b0, (i == LL), $sformatf("p%0d", i));

    repeat (20) @(negedge clk);
    while (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s got no check by cyc=%0d want check at cyc=%0d", sb[0].name, cyc, sb[0].at);
      sb.delete(0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
